// File: rtl/scan_insert_ctrl_pkg.sv
// rtl/scan_insert_ctrl_pkg.sv - shared op-codes, FSM states and cell control fields
package samDefines;

    typedef enum logic [1:0] {
        OP_CONFIG = 2'd0,
        OP_SCAN   = 2'd1,
        OP_INSERT = 2'd2,
        OP_RSVD   = 2'd3
    } cmdOp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_LATCH,
        ST_CMP,
        ST_CAPT,
        ST_SHIFT,
        ST_RESP
    } ctrlState_t;

    typedef struct packed {
        logic cfg;
        logic isScan;
        logic rowTypeInx;
    } cellCtrl_t;

endpackage

// File: rtl/scan_insert_ctrl_if.sv
// rtl/scan_insert_ctrl_if.sv - command/response handshake bundle for scan_insert_ctrl
interface scan_insert_ctrl_if #(
    parameter int CELL_SIZE = 8,
    parameter int IDX_W     = 5
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [CELL_SIZE-1:0] cmd_target;
    logic                 cmd_rowTypeInx;
    logic [IDX_W-1:0]     cmd_insIdx;
    logic [IDX_W-1:0]     cmd_endIdx;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_rslt;
    logic                 rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_target, cmd_rowTypeInx, cmd_insIdx, cmd_endIdx, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rslt, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_target, cmd_rowTypeInx, cmd_insIdx, cmd_endIdx, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rslt, rsp_err
    );
endinterface

// File: rtl/scan_insert_ctrl_ins_mask_gen.sv
// rtl/scan_insert_ctrl_ins_mask_gen.sv - insert-point and shift-enable mask generator
module ins_mask_gen #(
    parameter int NUM_CELLS = 32,
    parameter int IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic [IDX_W-1:0]     insIdx,
    input  logic [IDX_W-1:0]     endIdx,
    output logic [NUM_CELLS-1:0] insPt,
    output logic [NUM_CELLS-1:0] doShift
);

    // Cells above the insertion point up to the group end move one slot right.
    always_comb begin
        insPt   = '0;
        doShift = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            insPt[i]   = (i == int'(insIdx));
            doShift[i] = (i > int'(insIdx)) && (i <= int'(endIdx));
        end
    end

endmodule

// File: rtl/scan_insert_ctrl.sv
// rtl/scan_insert_ctrl.sv - sequences CONFIG/SCAN/INSERT commands onto the row-buffer cell array
module scan_insert_ctrl
    import samDefines::*;
#(
    parameter int NUM_CELLS = 32,
    parameter int CELL_SIZE = 8,
    parameter int IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic                 clk,
    input  logic                 reset,
    scan_insert_ctrl_if.slave    bus,
    output logic                 cfg_o,
    output logic                 isScan_o,
    output logic                 rowTypeInx_o,
    output logic [CELL_SIZE-1:0] target_o,
    output logic [NUM_CELLS-1:0] insPt_o,
    output logic [NUM_CELLS-1:0] doShift_o,
    input  logic [1:0]           rslt_i
);

    ctrlState_t           state;
    ctrlState_t           nextState;
    cellCtrl_t            ctrl;
    logic                 accept;
    logic                 cmdErr;
    logic                 rowTypeReg;
    logic [IDX_W-1:0]     insIdx;
    logic [IDX_W-1:0]     endIdx;
    logic [NUM_CELLS-1:0] insMask;
    logic [NUM_CELLS-1:0] shiftMask;

    assign accept = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        cmdErr = 1'b0;
        case (cmdOp_t'(bus.cmd_op))
            OP_INSERT: cmdErr = (bus.cmd_insIdx > bus.cmd_endIdx) ||
                                (int'(bus.cmd_endIdx) >= NUM_CELLS);
            OP_RSVD:   cmdErr = 1'b1;
            default:   cmdErr = 1'b0;
        endcase
    end

    ins_mask_gen #(.NUM_CELLS(NUM_CELLS), .IDX_W(IDX_W)) u_maskGen (
        .insIdx (insIdx),
        .endIdx (endIdx),
        .insPt  (insMask),
        .doShift(shiftMask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmdErr) begin
                        nextState = ST_RESP;
                    end else begin
                        case (cmdOp_t'(bus.cmd_op))
                            OP_CONFIG: nextState = ST_CFG;
                            OP_SCAN:   nextState = ST_LATCH;
                            default:   nextState = ST_SHIFT;
                        endcase
                    end
                end
            end
            ST_CFG:   nextState = ST_RESP;
            ST_LATCH: nextState = ST_CMP;
            ST_CMP:   nextState = ST_CAPT;
            ST_CAPT:  nextState = ST_RESP;
            ST_SHIFT: nextState = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
    end

    // The compare result has rippled through the cell chain by the end of CAPT.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_o     <= '0;
            rowTypeReg   <= 1'b0;
            insIdx       <= '0;
            endIdx       <= '0;
            bus.rsp_rslt <= 2'b00;
            bus.rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                target_o     <= bus.cmd_target;
                rowTypeReg   <= bus.cmd_rowTypeInx;
                insIdx       <= bus.cmd_insIdx;
                endIdx       <= bus.cmd_endIdx;
                bus.rsp_rslt <= 2'b00;
                bus.rsp_err  <= cmdErr;
            end
            if (state == ST_CAPT) begin
                bus.rsp_rslt <= rslt_i;
            end
        end
    end

    always_comb begin
        ctrl            = '0;
        ctrl.rowTypeInx = rowTypeReg;
        insPt_o         = '0;
        doShift_o       = '0;
        bus.cmd_ready   = 1'b0;
        bus.rsp_valid   = 1'b0;
        case (state)
            ST_IDLE:  bus.cmd_ready = 1'b1;
            ST_CFG:   ctrl.cfg      = 1'b1;
            ST_LATCH: ctrl.isScan   = 1'b1;
            ST_SHIFT: begin
                insPt_o   = insMask;
                doShift_o = shiftMask;
            end
            ST_RESP:  bus.rsp_valid = 1'b1;
            default:  ;
        endcase
        // Keep the cell array quiet while reset is held, even before the state register clears.
        if (reset) begin
            ctrl.cfg    = 1'b0;
            ctrl.isScan = 1'b0;
            insPt_o     = '0;
            doShift_o   = '0;
        end
    end

    assign cfg_o        = ctrl.cfg;
    assign isScan_o     = ctrl.isScan;
    assign rowTypeInx_o = ctrl.rowTypeInx;

endmodule

// File: tb/tb_scan_insert_ctrl.sv
// tb/tb_scan_insert_ctrl.sv - scoreboard bench for scan_insert_ctrl
module tb_scan_insert_ctrl;

    localparam int NUM_CELLS = 32;
    localparam int CELL_SIZE = 8;
    localparam int IDX_W     = 5;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 cfg_o;
    logic                 isScan_o;
    logic                 rowTypeInx_o;
    logic [CELL_SIZE-1:0] target_o;
    logic [NUM_CELLS-1:0] insPt_o;
    logic [NUM_CELLS-1:0] doShift_o;
    logic [1:0]           rslt_i;

    int         nTests = 0;
    int         nFail  = 0;
    logic [2:0] expQ[$];
    logic       prevValid = 1'b0;

    scan_insert_ctrl_if #(.CELL_SIZE(CELL_SIZE), .IDX_W(IDX_W)) bus ();

    scan_insert_ctrl #(.NUM_CELLS(NUM_CELLS), .CELL_SIZE(CELL_SIZE), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .cfg_o       (cfg_o),
        .isScan_o    (isScan_o),
        .rowTypeInx_o(rowTypeInx_o),
        .target_o    (target_o),
        .insPt_o     (insPt_o),
        .doShift_o   (doShift_o),
        .rslt_i      (rslt_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares on the first cycle each response is presented.
    always @(negedge clk) begin
        logic [2:0] e;
        if (reset) begin
            prevValid = 1'b0;
        end else begin
            if (bus.rsp_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    chk("rsp_rslt", 32'(bus.rsp_rslt), 32'(e[2:1]));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e[0]));
                end
            end
            prevValid = bus.rsp_valid;
        end
    end

    task automatic chkQuiet(input string tag);
        chk({tag, "_cfg"},     32'(cfg_o), 32'd0);
        chk({tag, "_isScan"},  32'(isScan_o), 32'd0);
        chk({tag, "_insPt"},   insPt_o, 32'd0);
        chk({tag, "_doShift"}, doShift_o, 32'd0);
        chk({tag, "_rspValid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rspRslt"}, 32'(bus.rsp_rslt), 32'd0);
        chk({tag, "_rspErr"},  32'(bus.rsp_err), 32'd0);
        chk({tag, "_target"},  32'(target_o), 32'd0);
        chk({tag, "_rowType"}, 32'(rowTypeInx_o), 32'd0);
    endtask

    task automatic runCmd(input string tag, input logic [1:0] op, input logic [7:0] tgt,
                          input logic row, input logic [4:0] ins, input logic [4:0] endI,
                          input logic [1:0] model, input logic [1:0] expRslt, input logic expErr,
                          input int expCfgAt, input int expScanAt, input int expShiftAt,
                          input int expRespAt, input logic [31:0] expIns,
                          input logic [31:0] expShift, input int stall);
        int         n = 0;
        int         cyc = 1;
        int         cfgCnt = 0, scanCnt = 0, shiftCnt = 0, readyCnt = 0, badTgt = 0;
        int         cfgAt = 0, scanAt = 0, shiftAt = 0, respAt = 0;
        logic [31:0] insSeen = '0, shiftSeen = '0;
        logic [1:0]  heldRslt;
        expQ.push_back({expRslt, expErr});
        bus.cmd_op = op;
        bus.cmd_target = tgt;
        bus.cmd_rowTypeInx = row;
        bus.cmd_insIdx = ins;
        bus.cmd_endIdx = endI;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_acceptWait"}, 32'(n < 20), 32'd1);
        @(negedge clk);
        // A competing command stays valid for the whole operation and must be ignored.
        bus.cmd_op = 2'd0;
        bus.cmd_target = 8'hFF;
        bus.cmd_rowTypeInx = ~row;
        bus.cmd_insIdx = 5'd0;
        bus.cmd_endIdx = 5'd0;
        while (respAt == 0 && cyc <= 12) begin
            rslt_i = (cyc == 3) ? model : ~model;
            if (cfg_o) begin cfgCnt++; cfgAt = cyc; end
            if (isScan_o) begin scanCnt++; scanAt = cyc; end
            if (insPt_o != '0 || doShift_o != '0) begin
                shiftCnt++; shiftAt = cyc; insSeen = insPt_o; shiftSeen = doShift_o;
            end
            if (target_o !== tgt || rowTypeInx_o !== row) badTgt++;
            if (bus.cmd_ready) readyCnt++;
            if (bus.rsp_valid) respAt = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, "_respAt"},   32'(respAt), 32'(expRespAt));
        chk({tag, "_cfgCnt"},   32'(cfgCnt), 32'(expCfgAt != 0));
        chk({tag, "_cfgAt"},    32'(cfgAt), 32'(expCfgAt));
        chk({tag, "_scanCnt"},  32'(scanCnt), 32'(expScanAt != 0));
        chk({tag, "_scanAt"},   32'(scanAt), 32'(expScanAt));
        chk({tag, "_shiftCnt"}, 32'(shiftCnt), 32'(expShiftAt != 0));
        chk({tag, "_shiftAt"},  32'(shiftAt), 32'(expShiftAt));
        chk({tag, "_insPt"},    insSeen, expIns);
        chk({tag, "_doShift"},  shiftSeen, expShift);
        chk({tag, "_target"},   32'(badTgt), 32'd0);
        chk({tag, "_busy"},     32'(readyCnt), 32'd0);
        heldRslt = bus.rsp_rslt;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, "_stallValid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, "_stallRslt"},  32'(bus.rsp_rslt), 32'(heldRslt));
            chk({tag, "_stallErr"},   32'(bus.rsp_err), 32'(expErr));
            chk({tag, "_stallReady"}, 32'(bus.cmd_ready), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_idleReady"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_idleValid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_idleCfg"},   32'(cfg_o), 32'd0);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'd0;
        bus.cmd_target = '0;
        bus.cmd_rowTypeInx = 1'b0;
        bus.cmd_insIdx = '0;
        bus.cmd_endIdx = '0;
        bus.rsp_ready = 1'b0;
        rslt_i = 2'b00;
        repeat (3) @(negedge clk);
        chkQuiet("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("postReset_ready", 32'(bus.cmd_ready), 32'd1);

        //     tag         op    tgt    row  ins    end    model  rslt   err cfg scn sh rsp insPt          doShift        stall
        runCmd("config",   2'd0, 8'hA5, 1'b0, 5'd0,  5'd0,  2'b11, 2'b00, 1'b0, 1, 0, 0, 2, 32'h0,         32'h0,         0);
        runCmd("scan",     2'd1, 8'h40, 1'b1, 5'd0,  5'd0,  2'b01, 2'b01, 1'b0, 0, 1, 0, 4, 32'h0,         32'h0,         0);
        runCmd("ins3_7",   2'd2, 8'h77, 1'b0, 5'd3,  5'd7,  2'b11, 2'b00, 1'b0, 0, 0, 1, 2, 32'h0000_0008, 32'h0000_00F0, 0);
        runCmd("ins5_2",   2'd2, 8'h12, 1'b1, 5'd5,  5'd2,  2'b11, 2'b00, 1'b1, 0, 0, 0, 1, 32'h0,         32'h0,         0);
        runCmd("op3",      2'd3, 8'h34, 1'b0, 5'd1,  5'd6,  2'b11, 2'b00, 1'b1, 0, 0, 0, 1, 32'h0,         32'h0,         0);
        runCmd("ins4_4",   2'd2, 8'h56, 1'b1, 5'd4,  5'd4,  2'b11, 2'b00, 1'b0, 0, 0, 1, 2, 32'h0000_0010, 32'h0,         0);
        runCmd("scanStall",2'd1, 8'h9C, 1'b0, 5'd0,  5'd0,  2'b10, 2'b10, 1'b0, 0, 1, 0, 4, 32'h0,         32'h0,         4);
        runCmd("ins0_31",  2'd2, 8'hE1, 1'b0, 5'd0,  5'd31, 2'b11, 2'b00, 1'b0, 0, 0, 1, 2, 32'h0000_0001, 32'hFFFF_FFFE, 0);

        // Abort a SCAN while it sits in CMP; no response may follow.
        bus.cmd_op = 2'd1;
        bus.cmd_target = 8'h3C;
        bus.cmd_rowTypeInx = 1'b1;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("abort_latch", 32'(isScan_o), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chkQuiet("abort");
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("abort_noRsp", 32'(bus.rsp_valid), 32'd0);
        end

        runCmd("scanAfter",2'd1, 8'h5A, 1'b1, 5'd0,  5'd0,  2'b11, 2'b11, 1'b0, 0, 1, 0, 4, 32'h0,         32'h0,         1);

        repeat (3) @(negedge clk);
        chk("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
